// File: rtl/db_pkg.sv
// Shared types and constants for the shared data-bus arbiter.
// Requester indices follow the legacy bus controller ordering.
package db_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_e;

    localparam int REQ_PROC = 0;
    localparam int REQ_IO1  = 1;
    localparam int REQ_IO2  = 2;
    localparam int REQ_MEM  = 3;
    localparam int REQ_DMA  = 4;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Wide enough for the largest allowed hold limit (255).
    localparam int HOLD_W = 8;

endpackage

// File: rtl/db_rr_pick.sv
// Combinational masked priority picker: the first asserted request at or after
// the start index wins, where the start is rr_ptr in round-robin mode and 0 otherwise.
module db_rr_pick
    import db_pkg::*;
#(
    parameter int N_REQ = 5,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  rr_ptr_i,
    input  logic             mode_i,
    output logic [N_REQ-1:0] win_oh_o,
    output logic [ID_W-1:0]  win_idx_o,
    output logic             any_valid_o
);

    int start;
    int idx;

    always_comb begin
        win_oh_o    = '0;
        win_idx_o   = '0;
        any_valid_o = 1'b0;
        start       = (mode_i == MODE_RR) ? int'(rr_ptr_i) : 0;
        idx         = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = start + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!any_valid_o && req_i[idx]) begin
                any_valid_o   = 1'b1;
                win_oh_o[idx] = 1'b1;
                win_idx_o     = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/db_bus_arbiter.sv
// Clocked shared data-bus arbiter: registered one-hot grant, hold-until-release,
// one-cycle turnaround, and hold-timeout preemption that the owner can lock out.
module db_bus_arbiter
    import db_pkg::*;
#(
    parameter int N_REQ    = 5,
    parameter int MAX_HOLD = 16,
    parameter int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] lock,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             bus_busy,
    output logic             preempt
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(N_REQ - 1);

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                preempt_q, preempt_d;

    logic [N_REQ-1:0]    win_oh;
    logic [ID_W-1:0]     win_idx;
    logic                any_valid;
    logic                others_active;

    db_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i       (req),
        .rr_ptr_i    (rr_q),
        .mode_i      (mode),
        .win_oh_o    (win_oh),
        .win_idx_o   (win_idx),
        .any_valid_o (any_valid)
    );

    assign others_active = |(req & ~grant_q);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        id_d      = id_q;
        rr_d      = rr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = OWN;
                    grant_d = win_oh;
                    id_d    = win_idx;
                    // The granting edge starts the first counted ownership cycle.
                    hold_d  = HOLD_W'(1);
                    rr_d    = (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;
                end
            end
            OWN: begin
                if (!req[id_q]) begin
                    state_d = TURN;
                    grant_d = '0;
                    id_d    = '0;
                end else if (hold_q == HOLD_MAX && others_active && !lock[id_q]) begin
                    state_d   = TURN;
                    grant_d   = '0;
                    id_d      = '0;
                    preempt_d = 1'b1;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            TURN: begin
                state_d = IDLE;
                hold_d  = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                id_d    = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            rr_q      <= '0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            rr_q      <= rr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = id_q;
    assign bus_busy = |grant_q;
    assign preempt  = preempt_q;

    a_grant_onehot0: assert property (@(posedge clk) $onehot0(grant));
    a_busy_matches:  assert property (@(posedge clk) bus_busy == (|grant));
    a_id_matches:    assert property (@(posedge clk) (grant != '0) |-> grant[grant_id]);

endmodule

// File: tb/tb_db_bus_arbiter.sv
// Directed and random-traffic bench for db_bus_arbiter with five requesters.
module tb_db_bus_arbiter;

    localparam int N    = 5;
    localparam int IDW  = 3;

    logic           clk;
    logic           rst_n;
    logic           mode;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           bus_busy;
    logic           preempt;

    int errors;
    int checks;

    db_bus_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .req      (req),
        .lock     (lock),
        .grant    (grant),
        .grant_id (grant_id),
        .bus_busy (bus_busy),
        .preempt  (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        mode  = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        mode  = 1'b0;
        tick();
        tick();
        checks++;
        if (grant !== 5'b00000) begin errors++; $display("FAIL reset_grant: got %b want %b", grant, 5'b00000); end
        checks++;
        if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", grant_id); end
        checks++;
        if (bus_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_busy); end
        checks++;
        if (preempt !== 1'b0) begin errors++; $display("FAIL reset_preempt: got %b want 0", preempt); end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (grant !== 5'b00000) begin errors++; $display("FAIL idle_no_req: got %b want %b", grant, 5'b00000); end
    endtask

    task automatic test_fixed();
        do_reset();
        mode = 1'b0;
        req  = 5'b11010;
        tick();
        checks++;
        if (grant !== 5'b00010) begin errors++; $display("FAIL fixed_grant: got %b want %b", grant, 5'b00010); end
        checks++;
        if (grant_id !== 3'd1) begin errors++; $display("FAIL fixed_id: got %0d want 1", grant_id); end
        checks++;
        if (bus_busy !== 1'b1) begin errors++; $display("FAIL fixed_busy: got %b want 1", bus_busy); end
        repeat (2) tick();
        checks++;
        if (grant !== 5'b00010) begin errors++; $display("FAIL fixed_hold: got %b want %b", grant, 5'b00010); end
        req = 5'b11000;
        tick();
        checks++;
        if (grant !== 5'b00000) begin errors++; $display("FAIL fixed_turn: got %b want %b", grant, 5'b00000); end
        tick();
        checks++;
        if (grant !== 5'b00000) begin errors++; $display("FAIL fixed_idle_gap: got %b want %b", grant, 5'b00000); end
        tick();
        checks++;
        if (grant_id !== 3'd3 || grant !== 5'b01000) begin
            errors++; $display("FAIL fixed_next: got id %0d grant %b want id 3 grant %b", grant_id, grant, 5'b01000);
        end
    endtask

    task automatic test_round_robin();
        logic [IDW-1:0] exp_id;
        logic [N-1:0]   exp_g;
        do_reset();
        mode = 1'b1;
        req  = 5'b11111;
        tick();
        for (int k = 0; k < 6; k++) begin
            exp_id = IDW'(k % N);
            exp_g  = 5'b00001 << exp_id;
            checks++;
            if (grant_id !== exp_id || grant !== exp_g) begin
                errors++; $display("FAIL rr_order[%0d]: got id %0d grant %b want id %0d grant %b", k, grant_id, grant, exp_id, exp_g);
            end
            repeat (2) tick();
            req[exp_id] = 1'b0;
            tick();
            checks++;
            if (grant !== 5'b00000) begin errors++; $display("FAIL rr_turn[%0d]: got %b want %b", k, grant, 5'b00000); end
            req = 5'b11111;
            tick();
            checks++;
            if (grant !== 5'b00000) begin errors++; $display("FAIL rr_idle[%0d]: got %b want %b", k, grant, 5'b00000); end
            tick();
        end
    endtask

    // DMA owns from cycle 1, processor requests from cycle 5; returns at cycle 16.
    task automatic dma_to_cycle16(input logic [N-1:0] lk);
        do_reset();
        mode = 1'b0;
        lock = lk;
        req  = 5'b10000;
        tick();
        checks++;
        if (grant_id !== 3'd4) begin errors++; $display("FAIL dma_owns: got id %0d want 4", grant_id); end
        repeat (4) tick();
        req = 5'b10001;
        repeat (11) tick();
        checks++;
        if (grant !== 5'b10000 || preempt !== 1'b0) begin
            errors++; $display("FAIL dma_cycle16: got grant %b preempt %b want grant %b preempt 0", grant, preempt, 5'b10000);
        end
    endtask

    task automatic check_preempt_sequence(input string tag);
        tick();
        checks++;
        if (preempt !== 1'b1 || grant !== 5'b00000 || bus_busy !== 1'b0) begin
            errors++; $display("FAIL %s_pulse: got preempt %b grant %b busy %b want 1 00000 0", tag, preempt, grant, bus_busy);
        end
        tick();
        checks++;
        if (preempt !== 1'b0 || grant !== 5'b00000) begin
            errors++; $display("FAIL %s_after: got preempt %b grant %b want 0 00000", tag, preempt, grant);
        end
        tick();
        checks++;
        if (grant_id !== 3'd0 || grant !== 5'b00001) begin
            errors++; $display("FAIL %s_winner: got id %0d grant %b want id 0 grant 00001", tag, grant_id, grant);
        end
    endtask

    task automatic test_timeout();
        dma_to_cycle16(5'b00000);
        check_preempt_sequence("timeout");
    endtask

    task automatic test_lock();
        int seen_preempt;
        dma_to_cycle16(5'b10001);
        seen_preempt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (preempt !== 1'b0) seen_preempt++;
        end
        checks++;
        if (seen_preempt != 0 || grant !== 5'b10000) begin
            errors++; $display("FAIL lock_hold: got preempts %0d grant %b want 0 and %b", seen_preempt, grant, 5'b10000);
        end
        req = 5'b00001;
        tick();
        checks++;
        if (grant !== 5'b00000 || preempt !== 1'b0) begin
            errors++; $display("FAIL lock_release: got grant %b preempt %b want 00000 0", grant, preempt);
        end
        repeat (2) tick();
        checks++;
        if (grant_id !== 3'd0) begin errors++; $display("FAIL lock_next: got id %0d want 0", grant_id); end
        // Only a non-owner lock bit is set: the DMA owner stays preemptible.
        dma_to_cycle16(5'b00001);
        check_preempt_sequence("nonowner_lock");
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        mode = 1'b0;
        req  = 5'b00100;
        tick();
        tick();
        checks++;
        if (grant_id !== 3'd2) begin errors++; $display("FAIL mid_pre: got id %0d want 2", grant_id); end
        rst_n = 1'b0;
        tick();
        checks++;
        if (grant !== 5'b00000 || grant_id !== 3'd0 || bus_busy !== 1'b0 || preempt !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got grant %b id %0d busy %b preempt %b want all 0", grant, grant_id, bus_busy, preempt);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (grant_id !== 3'd2 || grant !== 5'b00100) begin
            errors++; $display("FAIL mid_regrant: got id %0d grant %b want id 2 grant 00100", grant_id, grant);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        mode = 1'b0;
        req  = 5'b00011;
        tick();
        repeat (15) tick();
        checks++;
        if (grant !== 5'b00001) begin errors++; $display("FAIL simul_c16: got %b want 00001", grant); end
        req = 5'b00010;
        tick();
        checks++;
        if (preempt !== 1'b0 || grant !== 5'b00000) begin
            errors++; $display("FAIL simul_turn: got preempt %b grant %b want 0 00000", preempt, grant);
        end
        repeat (2) tick();
        checks++;
        if (grant_id !== 3'd1) begin errors++; $display("FAIL simul_next: got id %0d want 1", grant_id); end
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        bad = 0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 7) == 0) req  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) lock = 5'($urandom_range(0, 31));
            mode = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if ((grant & (grant - 5'd1)) !== 5'b00000 || bus_busy !== (|grant)) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_onehot_busy: got grant %b busy %b", grant, bus_busy);
            end
            checks++;
            if ((grant !== 5'b00000 && grant !== (5'b00001 << grant_id)) ||
                (grant === 5'b00000 && grant_id !== 3'd0) ||
                (preempt === 1'b1 && grant !== 5'b00000)) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_id: got grant %b id %0d preempt %b", grant, grant_id, preempt);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        req    = '0;
        lock   = '0;
        mode   = 1'b0;
        test_reset();
        test_fixed();
        test_round_robin();
        test_timeout();
        test_lock();
        test_reset_mid_grant();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
